// File: rtl/onehot_mon_pkg.sv
// Shared types and error codes for the one-hot state monitors.
package onehot_mon_pkg;

  typedef enum logic [1:0] {
    MON_INIT  = 2'd0,
    MON_TRACK = 2'd1,
    MON_ERR   = 2'd2
  } mon_state_e;

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_ZERO  = 2'b01;
  localparam logic [1:0] ERR_MULTI = 2'b10;

endpackage

// File: rtl/onehot_enc.sv
// One-hot to binary encoder with zero-hot / multi-hot classification.
module onehot_enc #(
  parameter int NUM_STATES = 5,
  parameter int IDX_W      = $clog2(NUM_STATES)
) (
  input  logic [NUM_STATES-1:0] state,
  output logic [IDX_W-1:0]      idx,
  output logic                  legal,
  output logic                  zero_hot,
  output logic                  multi_hot
);

  // Clearing the lowest set bit leaves a non-zero value only when two or more bits are set.
  assign zero_hot  = ~|state;
  assign multi_hot = |(state & (state - 1'b1));
  assign legal     = ~zero_hot & ~multi_hot;

  always_comb begin
    idx = '0;
    for (int i = 0; i < NUM_STATES; i++) begin
      if (state[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/onehot_state_mon.sv
// Observes a one-hot state register: decodes the index, flags illegal encodings,
// pulses on transitions, counts dwell time and raises a stuck-state timeout.
module onehot_state_mon
  import onehot_mon_pkg::*;
#(
  parameter int NUM_STATES = 5,
  parameter int IDX_W      = $clog2(NUM_STATES),
  parameter int DWELL_W    = 8,
  parameter int TIMEOUT    = 200,
  parameter int IDLE_IDX   = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_STATES-1:0] state,
  input  logic                  clr_err,
  output logic [IDX_W-1:0]      state_idx,
  output logic                  state_vld,
  output logic                  trans,
  output logic [IDX_W-1:0]      prev_idx,
  output logic [DWELL_W-1:0]    dwell,
  output logic                  timeout,
  output logic                  illegal,
  output logic [1:0]            err_code
);

  logic [IDX_W-1:0] enc_idx;
  logic             enc_legal, enc_zero, enc_multi;

  onehot_enc #(.NUM_STATES(NUM_STATES), .IDX_W(IDX_W)) u_enc (
    .state     (state),
    .idx       (enc_idx),
    .legal     (enc_legal),
    .zero_hot  (enc_zero),
    .multi_hot (enc_multi)
  );

  mon_state_e       mon_q, mon_d;
  logic [IDX_W-1:0] state_idx_q, state_idx_d, prev_idx_q, prev_idx_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic             state_vld_q, state_vld_d, trans_q, trans_d;
  logic             timeout_q, timeout_d, illegal_q, illegal_d;
  logic [1:0]       err_code_q, err_code_d;

  always_comb begin
    mon_d       = mon_q;
    state_idx_d = state_idx_q;
    prev_idx_d  = prev_idx_q;
    dwell_d     = dwell_q;
    state_vld_d = state_vld_q;
    trans_d     = 1'b0;
    timeout_d   = timeout_q;
    illegal_d   = illegal_q;
    err_code_d  = err_code_q;

    if (clr_err) begin
      illegal_d  = 1'b0;
      err_code_d = ERR_NONE;
      timeout_d  = 1'b0;
    end

    if (!enc_legal) begin
      mon_d       = MON_ERR;
      state_vld_d = 1'b0;
      illegal_d   = 1'b1;
      err_code_d  = enc_zero ? ERR_ZERO : ERR_MULTI;
    end else if (mon_q == MON_INIT) begin
      mon_d       = MON_TRACK;
      state_vld_d = 1'b1;
      state_idx_d = enc_idx;
      prev_idx_d  = enc_idx;
      dwell_d     = '0;
    end else begin
      // Recovery from MON_ERR follows the same path as ordinary tracking.
      mon_d       = MON_TRACK;
      state_vld_d = 1'b1;
      if (enc_idx != state_idx_q) begin
        trans_d     = 1'b1;
        prev_idx_d  = state_idx_q;
        state_idx_d = enc_idx;
        dwell_d     = '0;
        timeout_d   = 1'b0;
      end else if (dwell_q != {DWELL_W{1'b1}}) begin
        dwell_d = dwell_q + 1'b1;
      end
    end

    if (dwell_d >= DWELL_W'(TIMEOUT) && state_idx_d != IDX_W'(IDLE_IDX))
      timeout_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mon_q       <= MON_INIT;
      state_idx_q <= IDX_W'(IDLE_IDX);
      prev_idx_q  <= IDX_W'(IDLE_IDX);
      dwell_q     <= '0;
      state_vld_q <= 1'b0;
      trans_q     <= 1'b0;
      timeout_q   <= 1'b0;
      illegal_q   <= 1'b0;
      err_code_q  <= ERR_NONE;
    end else begin
      mon_q       <= mon_d;
      state_idx_q <= state_idx_d;
      prev_idx_q  <= prev_idx_d;
      dwell_q     <= dwell_d;
      state_vld_q <= state_vld_d;
      trans_q     <= trans_d;
      timeout_q   <= timeout_d;
      illegal_q   <= illegal_d;
      err_code_q  <= err_code_d;
    end
  end

  assign state_idx = state_idx_q;
  assign prev_idx  = prev_idx_q;
  assign dwell     = dwell_q;
  assign state_vld = state_vld_q;
  assign trans     = trans_q;
  assign timeout   = timeout_q;
  assign illegal   = illegal_q;
  assign err_code  = err_code_q;

endmodule

// File: tb/tb_onehot_state_mon.sv
// Directed bench for onehot_state_mon with small dwell/timeout sizes.
module tb_onehot_state_mon;

  localparam int NS = 5, IW = 3, DW = 4, TO = 10;

  logic          clk = 1'b0;
  logic          rst, clr_err;
  logic [NS-1:0] state;
  logic [IW-1:0] state_idx, prev_idx;
  logic          state_vld, trans, timeout, illegal;
  logic [DW-1:0] dwell;
  logic [1:0]    err_code;

  int errors = 0;
  int checks = 0;

  onehot_state_mon #(
    .NUM_STATES(NS), .IDX_W(IW), .DWELL_W(DW), .TIMEOUT(TO), .IDLE_IDX(0)
  ) dut (
    .clk(clk), .rst(rst), .state(state), .clr_err(clr_err),
    .state_idx(state_idx), .state_vld(state_vld), .trans(trans),
    .prev_idx(prev_idx), .dwell(dwell), .timeout(timeout),
    .illegal(illegal), .err_code(err_code)
  );

  always #5 clk = ~clk;

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; clr_err = 1'b0; state = 5'b01000;
    step(2);
    checks++; if (state_idx !== 3'd0) begin errors++; $display("FAIL rst_idx got=%0d exp=0", state_idx); end
    checks++; if (prev_idx !== 3'd0) begin errors++; $display("FAIL rst_prev got=%0d exp=0", prev_idx); end
    checks++; if ({state_vld, trans, timeout, illegal} !== 4'b0) begin errors++; $display("FAIL rst_flags got=%b exp=0000", {state_vld, trans, timeout, illegal}); end
    checks++; if (dwell !== 4'd0 || err_code !== 2'b00) begin errors++; $display("FAIL rst_dwell_err got=%0d/%b exp=0/00", dwell, err_code); end
    rst = 1'b0; state = 5'b00001;
    step();
    checks++; if (state_vld !== 1'b1 || state_idx !== 3'd0 || trans !== 1'b0) begin errors++; $display("FAIL first_legal got vld=%b idx=%0d tr=%b exp 1/0/0", state_vld, state_idx, trans); end
    checks++; if (dwell !== 4'd0 || illegal !== 1'b0 || err_code !== 2'b00) begin errors++; $display("FAIL first_legal_misc got dw=%0d il=%b ec=%b exp 0/0/00", dwell, illegal, err_code); end
  endtask

  task automatic test_transition();
    step(2);
    checks++; if (dwell !== 4'd2 || trans !== 1'b0) begin errors++; $display("FAIL hold_idle got dw=%0d tr=%b exp 2/0", dwell, trans); end
    state = 5'b00100;
    step();
    checks++; if (trans !== 1'b1 || state_idx !== 3'd2 || prev_idx !== 3'd0 || dwell !== 4'd0) begin errors++; $display("FAIL trans got tr=%b idx=%0d prev=%0d dw=%0d exp 1/2/0/0", trans, state_idx, prev_idx, dwell); end
    step();
    checks++; if (trans !== 1'b0 || dwell !== 4'd1) begin errors++; $display("FAIL trans_pulse got tr=%b dw=%0d exp 0/1", trans, dwell); end
    step(3);
    checks++; if (dwell !== 4'd4 || state_idx !== 3'd2) begin errors++; $display("FAIL dwell4 got dw=%0d idx=%0d exp 4/2", dwell, state_idx); end
  endtask

  task automatic test_illegal();
    state = 5'b00000;
    step();
    checks++; if (illegal !== 1'b1 || err_code !== 2'b01 || state_vld !== 1'b0) begin errors++; $display("FAIL zero_hot got il=%b ec=%b vld=%b exp 1/01/0", illegal, err_code, state_vld); end
    checks++; if (state_idx !== 3'd2 || dwell !== 4'd4 || trans !== 1'b0) begin errors++; $display("FAIL zero_hold got idx=%0d dw=%0d tr=%b exp 2/4/0", state_idx, dwell, trans); end
    state = 5'b01010;
    step();
    checks++; if (err_code !== 2'b10 || illegal !== 1'b1 || state_idx !== 3'd2) begin errors++; $display("FAIL multi_hot got ec=%b il=%b idx=%0d exp 10/1/2", err_code, illegal, state_idx); end
    state = 5'b00100;
    step();
    checks++; if (state_vld !== 1'b1 || trans !== 1'b0 || dwell !== 4'd5) begin errors++; $display("FAIL recover got vld=%b tr=%b dw=%0d exp 1/0/5", state_vld, trans, dwell); end
    checks++; if (illegal !== 1'b1 || err_code !== 2'b10) begin errors++; $display("FAIL sticky got il=%b ec=%b exp 1/10", illegal, err_code); end
  endtask

  task automatic test_clear();
    clr_err = 1'b1; state = 5'b00100;
    step();
    checks++; if (illegal !== 1'b0 || err_code !== 2'b00 || dwell !== 4'd6) begin errors++; $display("FAIL clr got il=%b ec=%b dw=%0d exp 0/00/6", illegal, err_code, dwell); end
    state = 5'b11000;
    step();
    checks++; if (illegal !== 1'b1 || err_code !== 2'b10 || state_vld !== 1'b0) begin errors++; $display("FAIL clr_collide got il=%b ec=%b vld=%b exp 1/10/0", illegal, err_code, state_vld); end
    clr_err = 1'b0;
  endtask

  task automatic test_timeout();
    state = 5'b01000;
    step();
    checks++; if (trans !== 1'b1 || state_idx !== 3'd3 || prev_idx !== 3'd2 || dwell !== 4'd0) begin errors++; $display("FAIL to_enter got tr=%b idx=%0d prev=%0d dw=%0d exp 1/3/2/0", trans, state_idx, prev_idx, dwell); end
    step(9);
    checks++; if (dwell !== 4'd9 || timeout !== 1'b0) begin errors++; $display("FAIL to_pre got dw=%0d to=%b exp 9/0", dwell, timeout); end
    step();
    checks++; if (dwell !== 4'd10 || timeout !== 1'b1) begin errors++; $display("FAIL to_set got dw=%0d to=%b exp 10/1", dwell, timeout); end
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    checks++; if (timeout !== 1'b1 || dwell !== 4'd11 || illegal !== 1'b0) begin errors++; $display("FAIL to_clr_collide got to=%b dw=%0d il=%b exp 1/11/0", timeout, dwell, illegal); end
    state = 5'b00001;
    step();
    checks++; if (trans !== 1'b1 || timeout !== 1'b0 || state_idx !== 3'd0 || prev_idx !== 3'd3) begin errors++; $display("FAIL to_leave got tr=%b to=%b idx=%0d prev=%0d exp 1/0/0/3", trans, timeout, state_idx, prev_idx); end
    step(50);
    checks++; if (timeout !== 1'b0 || dwell !== 4'd15) begin errors++; $display("FAIL idle_exempt got to=%b dw=%0d exp 0/15", timeout, dwell); end
  endtask

  task automatic test_sat_reset();
    state = 5'b10000;
    step();
    checks++; if (trans !== 1'b1 || state_idx !== 3'd4) begin errors++; $display("FAIL sat_enter got tr=%b idx=%0d exp 1/4", trans, state_idx); end
    step(19);
    checks++; if (dwell !== 4'd15 || timeout !== 1'b1) begin errors++; $display("FAIL sat got dw=%0d to=%b exp 15/1", dwell, timeout); end
    step(5);
    checks++; if (dwell !== 4'd15) begin errors++; $display("FAIL sat_hold got dw=%0d exp 15", dwell); end
    rst = 1'b1;
    step();
    checks++; if ({state_vld, trans, timeout, illegal} !== 4'b0 || dwell !== 4'd0 || err_code !== 2'b00) begin errors++; $display("FAIL mid_rst got fl=%b dw=%0d ec=%b exp 0000/0/00", {state_vld, trans, timeout, illegal}, dwell, err_code); end
    checks++; if (state_idx !== 3'd0 || prev_idx !== 3'd0) begin errors++; $display("FAIL mid_rst_idx got idx=%0d prev=%0d exp 0/0", state_idx, prev_idx); end
    rst = 1'b0;
    step();
    // First legal sample after reset is a capture, not a transition.
    checks++; if (trans !== 1'b0 || state_idx !== 3'd4 || prev_idx !== 3'd4 || state_vld !== 1'b1 || dwell !== 4'd0) begin errors++; $display("FAIL init_capture got tr=%b idx=%0d prev=%0d vld=%b dw=%0d exp 0/4/4/1/0", trans, state_idx, prev_idx, state_vld, dwell); end
  endtask

  initial begin
    test_reset();
    test_transition();
    test_illegal();
    test_clear();
    test_timeout();
    test_sat_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
